// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for eight 7-segment digits in two 4-digit groups.
// Each frame decodes from a snapshot of the inputs and every slot begins with a blanked gap.
module seg_scan_driver #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned DEAD     = 4
) (
    input  logic        sys_clk_in,
    input  logic        sys_rst,
    input  logic [31:0] disp_value,
    input  logic [7:0]  disp_en,
    input  logic [7:0]  disp_dp,
    input  logic        lz_blank,
    output logic [7:0]  seg_data_0_pin,
    output logic [7:0]  seg_data_1_pin,
    output logic [7:0]  seg_cs_pin,
    output logic        frame_tick
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t C_LAST = cnt_t'(SCAN_DIV - 1);

    cnt_t        r_c;
    logic [1:0]  r_idx;
    logic [31:0] r_sh_val;
    logic [7:0]  r_sh_en;
    logic [7:0]  r_sh_dp;
    logic        r_sh_lz;
    logic [7:0]  r_seg0;
    logic [7:0]  r_seg1;
    logic [7:0]  r_cs;
    logic        r_tick;

    logic        w_load;
    logic        w_wrap;
    logic        w_dead;
    cnt_t        w_c_next;
    logic [1:0]  w_idx_next;
    logic [31:0] w_val;
    logic [7:0]  w_en;
    logic [7:0]  w_dp;
    logic        w_lz;
    logic [7:0]  w_nz_from;
    logic [7:0]  w_supp;
    logic [2:0]  w_k0;
    logic [2:0]  w_k1;
    logic [3:0]  w_nib0;
    logic [3:0]  w_nib1;
    logic [6:0]  w_pat0;
    logic [6:0]  w_pat1;
    logic [7:0]  w_seg0_d;
    logic [7:0]  w_seg1_d;
    logic [7:0]  w_cs_d;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        unique case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            4'hF: pat = 7'h71;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    assign w_load     = (r_c == '0) && (r_idx == 2'd0);
    assign w_wrap     = (r_c == C_LAST);
    assign w_c_next   = w_wrap ? '0 : r_c + cnt_t'(1);
    assign w_idx_next = w_wrap ? r_idx + 2'd1 : r_idx;
    assign w_dead     = (32'(r_c) < DEAD);

    // Decode from the value being latched on a load edge so slot 0 never sees stale shadows.
    assign w_val = w_load ? disp_value : r_sh_val;
    assign w_en  = w_load ? disp_en    : r_sh_en;
    assign w_dp  = w_load ? disp_dp    : r_sh_dp;
    assign w_lz  = w_load ? lz_blank   : r_sh_lz;

    always_comb begin
        w_nz_from = '0;
        w_supp    = '0;
        for (int k = 0; k < 8; k++) begin
            w_nz_from[k] = ((w_val >> (4 * k)) != 32'd0);
            w_supp[k]    = w_lz && (k != 0) && !w_nz_from[k];
        end
    end

    assign w_k0   = {1'b0, r_idx};
    assign w_k1   = {1'b1, r_idx};
    assign w_nib0 = w_val[{w_k0, 2'b00} +: 4];
    assign w_nib1 = w_val[{w_k1, 2'b00} +: 4];
    assign w_pat0 = w_supp[w_k0] ? 7'h00 : hex7(w_nib0);
    assign w_pat1 = w_supp[w_k1] ? 7'h00 : hex7(w_nib1);

    always_comb begin
        w_cs_d   = 8'h00;
        w_seg0_d = 8'hFF;
        w_seg1_d = 8'hFF;
        if (!w_dead) begin
            w_cs_d[w_k0] = w_en[w_k0];
            w_cs_d[w_k1] = w_en[w_k1];
            w_seg0_d     = ~{w_dp[w_k0], w_pat0};
            w_seg1_d     = ~{w_dp[w_k1], w_pat1};
        end
    end

    always_ff @(posedge sys_clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            r_c      <= '0;
            r_idx    <= 2'd0;
            r_sh_val <= 32'd0;
            r_sh_en  <= 8'h00;
            r_sh_dp  <= 8'h00;
            r_sh_lz  <= 1'b0;
        end else begin
            r_c   <= w_c_next;
            r_idx <= w_idx_next;
            if (w_load) begin
                r_sh_val <= disp_value;
                r_sh_en  <= disp_en;
                r_sh_dp  <= disp_dp;
                r_sh_lz  <= lz_blank;
            end
        end
    end

    always_ff @(posedge sys_clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            r_seg0 <= 8'hFF;
            r_seg1 <= 8'hFF;
            r_cs   <= 8'h00;
            r_tick <= 1'b0;
        end else begin
            r_seg0 <= w_seg0_d;
            r_seg1 <= w_seg1_d;
            r_cs   <= w_cs_d;
            r_tick <= w_load;
        end
    end

    assign seg_data_0_pin = r_seg0;
    assign seg_data_1_pin = r_seg1;
    assign seg_cs_pin     = r_cs;
    assign frame_tick     = r_tick;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: cycle model of the scan rules plus directed literal pins.
module tb_seg_scan_driver;

    localparam int SD = 8;
    localparam int DT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] disp_value = 32'd0;
    logic [7:0]  disp_en = 8'h00;
    logic [7:0]  disp_dp = 8'h00;
    logic        lz_blank = 1'b0;
    logic [7:0]  seg0;
    logic [7:0]  seg1;
    logic [7:0]  cs;
    logic        tick;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    seg_scan_driver #(.SCAN_DIV(SD), .DEAD(DT)) dut (
        .sys_clk_in     (clk),
        .sys_rst        (rst),
        .disp_value     (disp_value),
        .disp_en        (disp_en),
        .disp_dp        (disp_dp),
        .lz_blank       (lz_blank),
        .seg_data_0_pin (seg0),
        .seg_data_1_pin (seg1),
        .seg_cs_pin     (cs),
        .frame_tick     (tick)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: n counts edges since reset release; slot position follows from n alone.
    int          n = 0;
    logic [31:0] s_val = 32'd0;
    logic [7:0]  s_en = 8'h00;
    logic [7:0]  s_dp = 8'h00;
    logic        s_lz = 1'b0;
    logic [7:0]  exp_seg [2] = '{8'hFF, 8'hFF};
    logic [7:0]  exp_cs = 8'h00;
    logic        exp_tick = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n = 0;
            s_val = 32'd0; s_en = 8'h00; s_dp = 8'h00; s_lz = 1'b0;
            exp_seg[0] = 8'hFF; exp_seg[1] = 8'hFF; exp_cs = 8'h00; exp_tick = 1'b0;
        end else begin
            int cm, im;
            n++;
            cm = (n - 1) % SD;
            im = ((n - 1) / SD) % 4;
            exp_tick = (cm == 0 && im == 0);
            if (exp_tick) begin
                s_val = disp_value; s_en = disp_en; s_dp = disp_dp; s_lz = lz_blank;
            end
            exp_cs = 8'h00;
            exp_seg[0] = 8'hFF;
            exp_seg[1] = 8'hFF;
            if (cm >= DT) begin
                for (int g = 0; g < 2; g++) begin
                    int k;
                    logic [31:0] upper;
                    logic [6:0]  pat;
                    k = im + 4 * g;
                    upper = s_val >> (4 * k);
                    pat = (s_lz && k >= 1 && upper == 32'd0) ? 7'h00 : hex_tbl[upper[3:0]];
                    exp_seg[g] = ~{s_dp[k], pat};
                    exp_cs[k] = s_en[k];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s n=%0d got %0h want %0h", nm, n, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_seg0", {24'd0, seg0}, {24'd0, exp_seg[0]});
            chk("model_seg1", {24'd0, seg1}, {24'd0, exp_seg[1]});
            chk("model_cs",   {24'd0, cs},   {24'd0, exp_cs});
            chk("model_tick", {31'd0, tick}, {31'd0, exp_tick});
        end
    end

    task automatic wait_n(input int t);
        int b;
        b = 0;
        while (n != t && b < 2000) begin
            @(negedge clk);
            b++;
        end
        checks++;
        if (n != t) begin
            errors++;
            $display("FAIL wait_n got %0d want %0d", n, t);
        end
    endtask

    task automatic pin(input string nm, input logic [7:0] w0, input logic [7:0] w1,
                       input logic [7:0] wcs);
        chk({nm, "_seg0"}, {24'd0, seg0}, {24'd0, w0});
        chk({nm, "_seg1"}, {24'd0, seg1}, {24'd0, w1});
        chk({nm, "_cs"},   {24'd0, cs},   {24'd0, wcs});
    endtask

    initial begin
        #1 rst = 1'b1;
        disp_value = 32'h0000_0003; disp_en = 8'hFF; disp_dp = 8'h00; lz_blank = 1'b0;
        chk_en = 1'b1;
        @(negedge clk); @(negedge clk);
        pin("rst", 8'hFF, 8'hFF, 8'h00);
        chk("rst_tick", {31'd0, tick}, 32'd0);
        rst = 1'b0;

        // Basic decode
        wait_n(1); chk("tick_first", {31'd0, tick}, 32'd1);
        wait_n(2); chk("tick_drop", {31'd0, tick}, 32'd0); pin("blank2", 8'hFF, 8'hFF, 8'h00);
        wait_n(3);  pin("basic_s0", 8'hB0, 8'hC0, 8'h11);
        wait_n(11); pin("basic_s1", 8'hC0, 8'hC0, 8'h22);

        // Leading-zero suppression, takes effect at next snapshot
        wait_n(12); lz_blank = 1'b1; disp_dp = 8'h10;
        wait_n(19); pin("lz_pending", 8'hC0, 8'hC0, 8'h44);
        wait_n(35); pin("lz_s0", 8'hB0, 8'h7F, 8'h11);
        wait_n(43); pin("lz_s1", 8'hFF, 8'hFF, 8'h22);
        wait_n(59); pin("lz_s3", 8'hFF, 8'hFF, 8'h88);

        // Snapshot holds through a mid-frame change
        wait_n(60); disp_value = 32'h89AB_CDEF; lz_blank = 1'b0; disp_dp = 8'h00;
        wait_n(67); pin("snap_s0", 8'h8E, 8'h83, 8'h11);
        wait_n(75); disp_value = 32'h0;
        wait_n(77); pin("snap_s1", 8'h86, 8'h88, 8'h22);
        wait_n(85); pin("snap_s2", 8'hA1, 8'h90, 8'h44);
        wait_n(93); pin("snap_s3", 8'hC6, 8'h80, 8'h88);
        wait_n(97); chk("snap_tick", {31'd0, tick}, 32'd1);
        wait_n(99); pin("snap_new", 8'hC0, 8'hC0, 8'h11);

        // Dead time and enable gating
        wait_n(100); disp_en = 8'h0F;
        wait_n(129); chk("en_tick", {31'd0, tick}, 32'd1); pin("en_dead", 8'hFF, 8'hFF, 8'h00);
        wait_n(131); pin("en_s0", 8'hC0, 8'hC0, 8'h01);
        wait_n(137); pin("en_s1_dead", 8'hFF, 8'hFF, 8'h00);
        wait_n(139); pin("en_s1", 8'hC0, 8'hC0, 8'h02);
        wait_n(160); chk("period_lo", {31'd0, tick}, 32'd0);
        wait_n(161); chk("period_hi", {31'd0, tick}, 32'd1);

        // Asynchronous reset mid-slot 2
        wait_n(180);
        chk("pre_rst_cs", {24'd0, cs}, 32'h0000_0004);
        #2 rst = 1'b1;
        #1 pin("async_rst", 8'hFF, 8'hFF, 8'h00);
        chk("async_rst_tick", {31'd0, tick}, 32'd0);
        disp_value = 32'h0001_2000; disp_en = 8'hFF; disp_dp = 8'h01; lz_blank = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_n(1); chk("rel_tick", {31'd0, tick}, 32'd1); pin("rel_blank1", 8'hFF, 8'hFF, 8'h00);
        wait_n(2); pin("rel_blank2", 8'hFF, 8'hFF, 8'h00);
        wait_n(3);  pin("rel_s0", 8'h40, 8'hF9, 8'h11);
        wait_n(11); pin("rel_s1", 8'hC0, 8'hFF, 8'h22);
        wait_n(64);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
